// File: rtl/trace_capture_buffer.sv
// Trace capture buffer for processor bring-up: records up to NUM_CH buses into a
// circular memory, stops POST_TRIG samples after a data-match trigger, replays oldest-first.
module trace_capture_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH-1:0]        trig_mask_i,
  input  logic [DATA_W-1:0]        trig_value_i,
  output logic [NUM_CH*DATA_W-1:0] rd_data_o,
  output logic [NUM_CH-1:0]        rd_chv_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic                     triggered_o,
  output logic                     overflow_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = AW;
  localparam int unsigned DW = NUM_CH * DATA_W;
  localparam int unsigned EW = DW + NUM_CH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_POST,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     post_cnt_q, post_cnt_d;
  logic              trig_q, trig_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [NUM_CH-1:0] rd_chv_q, rd_chv_d;
  logic              mem_we;
  logic              sample_c;
  logic              trig_hit_c;

  logic [EW-1:0]     mem [DEPTH];

  // Trigger hit: any eligible, valid channel whose data equals the compare value.
  always_comb begin
    trig_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (trig_mask_i[i] && ch_valid_i[i] &&
          (ch_data_i[i*DATA_W +: DATA_W] == trig_value_i)) begin
        trig_hit_c = 1'b1;
      end
    end
  end

  // An Arm on the same edge wins over any sample, so the sample is dropped.
  assign sample_c = (|ch_valid_i) && !arm_i &&
                    ((state_q == S_PRE) || (state_q == S_POST));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_d     = trig_q;
    ovf_d      = ovf_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_chv_d   = rd_chv_q;
    mem_we     = 1'b0;

    if (arm_i) begin
      state_d    = S_PRE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      trig_d     = 1'b0;
      ovf_d      = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          rd_valid_d = 1'b0;
        end
        S_PRE, S_POST: begin
          if (sample_c) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // Full buffer: the new sample replaces the oldest entry.
            if (count_q == CW'(DEPTH)) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              ovf_d    = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (state_q == S_PRE) begin
              if (trig_hit_c) begin
                trig_d = 1'b1;
                if (POST_TRIG == 0) begin
                  state_d = S_DONE;
                end else begin
                  state_d    = S_POST;
                  post_cnt_d = PW'(POST_TRIG);
                end
              end
            end else begin
              post_cnt_d = post_cnt_q - PW'(1);
              if (post_cnt_q == PW'(1)) begin
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          // Registered read: prefetch the next entry on the accepting edge.
          if (rd_valid_q) begin
            if (rd_ready_i) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              count_d  = count_q - CW'(1);
              if (count_q > CW'(1)) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_ptr_d][DW-1:0];
                rd_chv_d   = mem[rd_ptr_d][EW-1:DW];
              end else begin
                rd_valid_d = 1'b0;
              end
            end
          end else if (count_q == '0) begin
            state_d = S_IDLE;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_ptr_q][DW-1:0];
            rd_chv_d   = mem[rd_ptr_q][EW-1:DW];
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_PRE) || (state_d == S_POST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_chv_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_q     <= trig_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_chv_q   <= rd_chv_d;
    end
  end

  // Trace storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= {ch_valid_i, ch_data_i};
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_chv_o    = rd_chv_q;
  assign rd_valid_o  = rd_valid_q;
  assign triggered_o = trig_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = busy_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: main instance with POST_TRIG=8 plus a
// POST_TRIG=0 instance sharing the same stimulus.
module tb_trace_capture_buffer;

  logic         clk;
  logic         rst_n;
  logic         arm;
  logic [95:0]  ch_data;
  logic [2:0]   ch_valid;
  logic [2:0]   trig_mask;
  logic [31:0]  trig_value;
  logic         rd_ready;

  logic [95:0]  rd_data;
  logic [2:0]   rd_chv;
  logic         rd_valid;
  logic         triggered;
  logic         overflow;
  logic         busy;
  logic [4:0]   count;

  logic [95:0]  b_rd_data;
  logic [2:0]   b_rd_chv;
  logic         b_rd_valid;
  logic         b_triggered;
  logic         b_overflow;
  logic         b_busy;
  logic [4:0]   b_count;

  int checks   = 0;
  int failures = 0;
  logic [98:0] exp_q[$];

  trace_capture_buffer #(.DATA_W(32), .NUM_CH(3), .DEPTH(16), .POST_TRIG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .trig_mask_i(trig_mask), .trig_value_i(trig_value), .rd_data_o(rd_data),
    .rd_chv_o(rd_chv), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .triggered_o(triggered), .overflow_o(overflow), .busy_o(busy), .count_o(count)
  );

  trace_capture_buffer #(.DATA_W(32), .NUM_CH(3), .DEPTH(16), .POST_TRIG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .trig_mask_i(trig_mask), .trig_value_i(trig_value), .rd_data_o(b_rd_data),
    .rd_chv_o(b_rd_chv), .rd_valid_o(b_rd_valid), .rd_ready_i(rd_ready),
    .triggered_o(b_triggered), .overflow_o(b_overflow), .busy_o(b_busy), .count_o(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    exp_q.delete();
  endtask

  // Drive one sample cycle; optionally record it in the expected-window model.
  task automatic feed(input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                      input logic [2:0] chv, input bit push);
    ch_data  = {d2, d1, d0};
    ch_valid = chv;
    if (push) begin
      exp_q.push_back({chv, d2, d1, d0});
      if (exp_q.size() > 16) void'(exp_q.pop_front());
    end
    step();
    ch_valid = 3'b000;
  endtask

  // Accept n entries, checking each against the model; bp selects ready pattern 1,0,0,1.
  task automatic drain(input int n, input bit bp);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 400) begin
      rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (rd_valid) begin
        chk("rd_entry", {29'd0, rd_chv, rd_data}, {29'd0, exp_q[0]});
        if (rd_ready) begin
          void'(exp_q.pop_front());
          idx++;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("drain_accepted", 128'(idx), 128'(n));
  endtask

  initial begin
    rst_n      = 1'b0;
    arm        = 1'b0;
    ch_data    = '0;
    ch_valid   = '0;
    trig_mask  = 3'b001;
    trig_value = 32'd5;
    rd_ready   = 1'b0;
    step();
    step();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_flags", {124'd0, triggered, overflow, busy, rd_valid}, 128'(0));
    chk("rst_rd_data", {29'd0, rd_chv, rd_data}, 128'(0));
    rst_n = 1'b1;
    step();

    // Basic trigger at sample 5, eight post-trigger samples.
    do_arm();
    chk("arm_busy", 128'(busy), 128'(1));
    for (int v = 1; v <= 13; v++) begin
      feed(32'd0, 32'd0, 32'(v), 3'b001, 1'b1);
      if (v == 4) chk("pre_trig_not_set", 128'(triggered), 128'(0));
      if (v == 5) chk("trig_set_at_5", 128'(triggered), 128'(1));
      if (v == 12) chk("post_busy_at_12", 128'(busy), 128'(1));
    end
    chk("basic_done_busy", 128'(busy), 128'(0));
    chk("basic_count", 128'(count), 128'(13));
    chk("basic_ovf", 128'(overflow), 128'(0));
    chk("basic_first_valid_late", 128'(rd_valid), 128'(0));
    drain(13, 1'b0);
    step();
    step();
    chk("basic_end_count", 128'(count), 128'(0));
    chk("basic_end_valid", 128'(rd_valid), 128'(0));
    feed(32'd0, 32'd0, 32'd77, 3'b001, 1'b0);
    chk("idle_no_capture", 128'(count), 128'(0));

    // Wrap and overflow: trigger at 30, stop after 38.
    trig_value = 32'd30;
    do_arm();
    for (int v = 1; v <= 38; v++) begin
      feed(32'd0, 32'd0, 32'(v), 3'b001, 1'b1);
      if (v == 16) chk("full_no_ovf", {123'd0, overflow, count}, {123'd0, 1'b0, 5'd16});
      if (v == 17) chk("ovf_at_17", {123'd0, overflow, count}, {123'd0, 1'b1, 5'd16});
    end
    chk("wrap_done_busy", 128'(busy), 128'(0));
    chk("wrap_count_ovf", {123'd0, overflow, count}, {123'd0, 1'b1, 5'd16});
    chk("wrap_model_first", 128'(exp_q[0][31:0]), 128'(23));
    drain(16, 1'b0);

    // Trigger qualification, then readout under backpressure.
    trig_value = 32'd5;
    trig_mask  = 3'b001;
    do_arm();
    feed(32'd0, 32'd5, 32'd0, 3'b010, 1'b1);
    chk("unmasked_ch1_no_trig", 128'(triggered), 128'(0));
    trig_mask = 3'b100;
    feed(32'd5, 32'd0, 32'd0, 3'b011, 1'b1);
    chk("invalid_ch2_no_trig", 128'(triggered), 128'(0));
    feed(32'd0, 32'd0, 32'd0, 3'b000, 1'b0);
    chk("idle_cycle_no_count", 128'(count), 128'(2));
    feed(32'd5, 32'd0, 32'd0, 3'b100, 1'b1);
    chk("ch2_trig", 128'(triggered), 128'(1));
    for (int v = 0; v < 8; v++) feed(32'd0, 32'd0, 32'(200 + v), 3'b001, 1'b1);
    chk("qual_count", {123'd0, busy, count}, {123'd0, 1'b0, 5'd11});
    drain(11, 1'b1);

    // Partial readout then re-Arm while six entries are pending.
    trig_mask  = 3'b001;
    trig_value = 32'd5;
    do_arm();
    for (int v = 1; v <= 13; v++) feed(32'd0, 32'd0, 32'(v), 3'b001, 1'b1);
    drain(7, 1'b0);
    chk("pending_count", 128'(count), 128'(6));
    trig_value = 32'd102;
    do_arm();
    chk("rearm_state", {122'd0, rd_valid, busy, count}, {122'd0, 1'b0, 1'b1, 5'd0});
    for (int v = 100; v <= 102; v++) feed(32'd0, 32'd0, 32'(v), 3'b001, 1'b0);
    chk("b_capture", {121'd0, b_triggered, b_overflow, b_busy, b_count},
        {121'd0, 1'b1, 1'b0, 1'b0, 5'd3});
    begin
      int idx = 0;
      int cyc = 0;
      rd_ready = 1'b1;
      while (idx < 3 && cyc < 20) begin
        if (b_rd_valid) begin
          chk("b_rd_entry", {29'd0, b_rd_chv, b_rd_data}, {29'd0, 3'b001, 64'd0, 32'(100 + idx)});
          idx++;
        end
        step();
        cyc++;
      end
      rd_ready = 1'b0;
      chk("b_accepted", 128'(idx), 128'(3));
      chk("b_end_count", 128'(b_count), 128'(0));
    end

    // Asynchronous reset mid-capture.
    trig_value = 32'd3;
    do_arm();
    for (int v = 1; v <= 5; v++) feed(32'd0, 32'd0, 32'(v), 3'b001, 1'b0);
    chk("pre_reset", {123'd0, triggered, count}, {123'd0, 1'b1, 5'd5});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {120'd0, triggered, busy, rd_valid, count}, 128'(0));
    step();
    rst_n = 1'b1;
    step();
    feed(32'd0, 32'd0, 32'd3, 3'b001, 1'b0);
    chk("post_rst_idle", {122'd0, busy, triggered, count}, 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
